// File: rtl/prog_clk_div_if.sv
// prog_clk_div_if: control/status and divided-clock outputs of prog_clk_div.
interface prog_clk_div_if #(parameter int CNT_W = 16);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic [CNT_W-1:0] div_cur;
    logic             div_pend;
    logic             div_err;
    logic             clkout;
    logic             clk_rise;
    logic             clk_fall;
    modport master (
        output en, div_val, div_load,
        input  div_cur, div_pend, div_err, clkout, clk_rise, clk_fall
    );
    modport slave (
        input  en, div_val, div_load,
        output div_cur, div_pend, div_err, clkout, clk_rise, clk_fall
    );
endinterface

// File: rtl/prog_clk_div.sv
// prog_clk_div: runtime-programmable integer clock divider with rise/fall strobes.
// Define PROG_CLK_DIV_DUTY50_EN to add a negedge stage giving 50% duty on odd divisors.
module prog_clk_div #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 5
) (
    input logic          clk,
    input logic          rst_n,
    prog_clk_div_if.slave bus
);
    logic [CNT_W-1:0] cnt, cnt_nxt, pend, div_cur;
    logic div_pend, div_err, clkout_p, clk_rise, clk_fall;
    logic wrap, p_nxt, load_ok;
    assign wrap    = cnt == div_cur - CNT_W'(1);
    assign cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    assign p_nxt   = cnt_nxt < (div_cur >> 1);
    assign load_ok = bus.div_load && bus.div_val >= CNT_W'(2);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= CNT_W'(DIV_DEFAULT - 1);
            div_cur  <= CNT_W'(DIV_DEFAULT);
            pend     <= '0;
            div_pend <= 1'b0;
            div_err  <= 1'b0;
            clkout_p <= 1'b0;
            clk_rise <= 1'b0;
            clk_fall <= 1'b0;
        end else begin
            div_err  <= bus.div_load && !load_ok;
            clk_rise <= bus.en && p_nxt && !clkout_p;
            clk_fall <= bus.en && !p_nxt && clkout_p;
            if (bus.en) begin
                cnt      <= cnt_nxt;
                clkout_p <= p_nxt;
                if (wrap && div_pend) begin
                    div_cur  <= pend;
                    div_pend <= 1'b0;
                end
            end
            // a load on the wrap edge re-arms pend for the following boundary
            if (load_ok) begin
                pend     <= bus.div_val;
                div_pend <= 1'b1;
            end
        end
    end
`ifdef PROG_CLK_DIV_DUTY50_EN
    logic clkout_n;
    always_ff @(negedge clk) begin
        if (!rst_n)
            clkout_n <= 1'b0;
        else if (bus.en)
            clkout_n <= clkout_p;
    end
    assign bus.clkout = clkout_p | (clkout_n & div_cur[0]);
`else
    assign bus.clkout = clkout_p;
`endif
    assign bus.div_cur  = div_cur;
    assign bus.div_pend = div_pend;
    assign bus.div_err  = div_err;
    assign bus.clk_rise = clk_rise;
    assign bus.clk_fall = clk_fall;
endmodule

// File: tb/tb_prog_clk_div.sv
// tb_prog_clk_div: randomized and directed stimulus against a period-level reference model.
module tb_prog_clk_div;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    prog_clk_div_if #(.CNT_W(16)) bus ();
    prog_clk_div #(.CNT_W(16), .DIV_DEFAULT(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] cur;
        logic        pend;
        logic        err;
        logic        ck;
        logic        rise;
        logic        fall;
    } obs_t;
    obs_t q[$];
    int n_pass = 0;
    int n_total = 0;

    // reference: period length, position inside the period, queued divisor
    int m_n = 5, m_pv = 0, m_ph = 4;
    bit m_pend = 0, m_high = 0, m_nreg = 0;

    task automatic step(input bit e, input bit ld, input int v, input bit r);
        bit err, rise, fall, lvl, nn, done;
        obs_t x;
        bus.en = e;
        bus.div_load = ld;
        bus.div_val = 16'(v);
        rst_n = r;
        err = 0; rise = 0; fall = 0;
        nn = !r ? 1'b0 : (e ? m_high : m_nreg);
        if (!r) begin
            m_n = 5; m_ph = 4; m_pend = 0; m_high = 0;
        end else begin
            err = ld && v < 2;
            if (e) begin
                done = m_ph == m_n - 1;
                if (done && m_pend) begin
                    m_n = m_pv;
                    m_pend = 0;
                end
                m_ph = done ? 0 : m_ph + 1;
                lvl = m_ph < m_n / 2;
                rise = lvl && !m_high;
                fall = !lvl && m_high;
                m_high = lvl;
            end
            if (ld && v >= 2) begin
                m_pv = v;
                m_pend = 1;
            end
        end
        m_nreg = nn;
        x.cur = 16'(m_n);
        x.pend = m_pend;
        x.err = err;
`ifdef PROG_CLK_DIV_DUTY50_EN
        x.ck = m_high | (nn & (m_n % 2 == 1));
`else
        x.ck = m_high;
`endif
        x.rise = rise;
        x.fall = fall;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1);
    endtask

    initial begin : monitor
        obs_t a, x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                a = '{cur: bus.div_cur, pend: bus.div_pend, err: bus.div_err,
                      ck: bus.clkout, rise: bus.clk_rise, fall: bus.clk_fall};
                n_total++;
                if (a == x) n_pass++;
                else $display("FAIL outputs t=%0t: got cur=%0d pend=%b err=%b clkout=%b rise=%b fall=%b, want cur=%0d pend=%b err=%b clkout=%b rise=%b fall=%b",
                              $time, a.cur, a.pend, a.err, a.ck, a.rise, a.fall,
                              x.cur, x.pend, x.err, x.ck, x.rise, x.fall);
            end
        end
    end

    initial begin : driver
        bus.en = 0;
        bus.div_load = 0;
        bus.div_val = '0;
        @(posedge clk);
        #2;
        // reset, then default divisor free-running
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        run(12);
        // load 4 while cnt=2
        while (m_ph != 2) step(1, 0, 0, 1);
        step(1, 1, 4, 1);
        run(14);
        // illegal loads
        step(1, 0, 0, 0);
        run(3);
        step(1, 1, 1, 1);
        step(1, 1, 0, 1);
        run(8);
        // back-to-back loads, last wins
        step(1, 1, 6, 1);
        step(1, 1, 9, 1);
        run(25);
        // freeze while high
        while (!m_high) step(1, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        run(20);
        // reset mid-period with divisor 9
        run(3);
        step(1, 0, 0, 0);
        run(12);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int v;
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            step($urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, v,
                 $urandom_range(0, 99) != 0);
        end
        // maximum divisor
        step(1, 0, 0, 0);
        step(1, 1, 65535, 1);
        run(65545);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
